// File: rtl/mem_sys_pkg.sv
// mem_sys_pkg
// Shared constants and types for the memory-system fetch path.
//   TEXT_BASE   : byte address of the first instruction ROM word
//   WORD_BYTES  : bytes per instruction word (pc step)
//   fetch_state_e : fetch unit control states
package mem_sys_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Bundles the ROM address/data pair, the redirect request, the valid/ready
// instruction output stage and the status outputs of the fetch unit.
//   master : fetch unit side (drives rom_addr, inst*, fetch_fault, fetch_count)
//   slave  : ROM / decode / control side
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic                  fetch_fault;
    logic [DATA_WIDTH-1:0] fetch_count;

    modport master (
        output rom_addr,
        input  rom_q,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output fetch_fault,
        output fetch_count
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  fetch_fault,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_addr_check.sv
// fetch_addr_check
// Combinational legality test for a fetch address: word aligned and inside
// [TEXT_BASE, TEXT_BASE + WORD_BYTES*(TEXT_WORDS-1)], unsigned compare.
//   i_pc    : byte address to test
//   o_legal : 1 when i_pc may be fetched
module fetch_addr_check #(
    parameter int              DATA_WIDTH = 32,
    parameter logic [31:0]     TEXT_BASE  = 32'h0040_0000,
    parameter int              TEXT_WORDS = 64
) (
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_legal
);
    import mem_sys_pkg::*;

    localparam logic [DATA_WIDTH-1:0] LO = DATA_WIDTH'(TEXT_BASE);
    localparam logic [DATA_WIDTH-1:0] HI =
        DATA_WIDTH'(TEXT_BASE) + DATA_WIDTH'(WORD_BYTES * (TEXT_WORDS - 1));

    logic w_aligned;
    logic w_in_range;

    assign w_aligned  = (i_pc[1:0] == 2'b00);
    assign w_in_range = (i_pc >= LO) && (i_pc <= HI);
    assign o_legal    = w_aligned && w_in_range;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Owns the program counter, presents it to the combinational instruction
// ROM and registers the returned word into a valid/ready output stage.
// Sequential fetch, back-pressure hold, redirect, sticky fault on an
// illegal (misaligned or out-of-segment) pc.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : instr_fetch_unit_if.master (ROM port, redirect, inst stage, status)
module instr_fetch_unit #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] TEXT_BASE  = mem_sys_pkg::TEXT_BASE,
    parameter int          TEXT_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_fetch_unit_if.master       bus
);
    import mem_sys_pkg::*;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(WORD_BYTES);

    fetch_state_e          r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_pc, w_pc_next;
    logic [DATA_WIDTH-1:0] r_inst, w_inst_next;
    logic [DATA_WIDTH-1:0] r_inst_pc, w_inst_pc_next;
    logic                  r_valid, w_valid_next;
    logic                  r_fault, w_fault_next;
    logic [DATA_WIDTH-1:0] r_count, w_count_next;

    logic w_pc_legal;
    logic w_load_slot;
    logic w_handshake;

    fetch_addr_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .TEXT_BASE  (TEXT_BASE),
        .TEXT_WORDS (TEXT_WORDS)
    ) u_addr_check (
        .i_pc    (r_pc),
        .o_legal (w_pc_legal)
    );

    // The output stage can take a new word when empty or being drained.
    assign w_load_slot = (r_state == FETCH) && (!r_valid || bus.inst_ready);
    assign w_handshake = r_valid && bus.inst_ready;

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_inst_next    = r_inst;
        w_inst_pc_next = r_inst_pc;
        w_valid_next   = r_valid;
        w_fault_next   = r_fault;
        // A handshake on a word being flushed by a redirect still counts.
        w_count_next   = w_handshake ? r_count + DATA_WIDTH'(1) : r_count;

        if (bus.redirect_valid) begin
            w_pc_next    = bus.redirect_pc;
            w_valid_next = 1'b0;
            w_fault_next = 1'b0;
            w_state_next = FETCH;
        end else if (w_load_slot) begin
            if (w_pc_legal) begin
                w_inst_next    = bus.rom_q;
                w_inst_pc_next = r_pc;
                w_valid_next   = 1'b1;
                w_pc_next      = r_pc + PC_STEP;
            end else begin
                // pc left untouched so the faulting address stays visible.
                w_state_next = HALT;
                w_fault_next = 1'b1;
                w_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_pc      <= DATA_WIDTH'(TEXT_BASE);
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_inst    <= w_inst_next;
            r_inst_pc <= w_inst_pc_next;
            r_valid   <= w_valid_next;
            r_fault   <= w_fault_next;
            r_count   <= w_count_next;
        end
    end

    assign bus.rom_addr    = r_pc;
    assign bus.inst        = r_inst;
    assign bus.inst_pc     = r_inst_pc;
    assign bus.inst_valid  = r_valid;
    assign bus.fetch_fault = r_fault;
    assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed bench: ROM model with word k = 32'hA000_0000 + k, linear steps,
// hand-computed expectations checked one edge at a time.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    instr_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .TEXT_BASE  (32'h0040_0000),
        .TEXT_WORDS (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'h0040_0000;
        if (addr[1:0] == 2'b00 && addr >= 32'h0040_0000 && addr <= 32'h0040_00FC)
            return 32'hA000_0000 + (off >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    always_comb bus.rom_q = rom_word(bus.rom_addr);

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [31:0] addr,
                             input logic f, input logic [31:0] cnt,
                             input logic [31:0] ipc, input logic [31:0] iw);
        chk({tag, "_valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
        chk({tag, "_addr"},  bus.rom_addr, addr);
        chk({tag, "_fault"}, {31'd0, bus.fetch_fault}, {31'd0, f});
        chk({tag, "_count"}, bus.fetch_count, cnt);
        if (v) begin
            chk({tag, "_ipc"},  bus.inst_pc, ipc);
            chk({tag, "_inst"}, bus.inst, iw);
        end
        $display("cyc %0d %s valid=%0b inst_pc=%h inst=%h rom_addr=%h fault=%0b count=%0d",
                 cyc, tag, bus.inst_valid, bus.inst_pc, bus.inst, bus.rom_addr,
                 bus.fetch_fault, bus.fetch_count);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset state
        step();
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_ipc",  bus.inst_pc, 32'h0);
        chk_state("reset", 1'b0, 32'h0040_0000, 1'b0, 0, 0, 0);

        // First word, then back-pressure for three edges
        rst_n = 1'b1;
        step(); chk_state("first", 1'b1, 32'h0040_0004, 1'b0, 0, 32'h0040_0000, 32'hA000_0000);
        step(); chk_state("hold1", 1'b1, 32'h0040_0004, 1'b0, 0, 32'h0040_0000, 32'hA000_0000);
        step(); chk_state("hold2", 1'b1, 32'h0040_0004, 1'b0, 0, 32'h0040_0000, 32'hA000_0000);
        step(); chk_state("hold3", 1'b1, 32'h0040_0004, 1'b0, 0, 32'h0040_0000, 32'hA000_0000);

        // Release: one word per cycle
        bus.inst_ready = 1'b1;
        step(); chk_state("seq1", 1'b1, 32'h0040_0008, 1'b0, 1, 32'h0040_0004, 32'hA000_0001);
        step(); chk_state("seq2", 1'b1, 32'h0040_000C, 1'b0, 2, 32'h0040_0008, 32'hA000_0002);
        step(); chk_state("seq3", 1'b1, 32'h0040_0010, 1'b0, 3, 32'h0040_000C, 32'hA000_0003);

        // Redirect while valid && !ready: word dropped, not counted
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0020;
        step(); chk_state("rd_flush", 1'b0, 32'h0040_0020, 1'b0, 3, 0, 0);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        step(); chk_state("rd_word", 1'b1, 32'h0040_0024, 1'b0, 3, 32'h0040_0020, 32'hA000_0008);
        step(); chk_state("rd_next", 1'b1, 32'h0040_0028, 1'b0, 4, 32'h0040_0024, 32'hA000_0009);

        // Redirect with ready high: flushed word's handshake still counts
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_00F8;
        step(); chk_state("rd_hs", 1'b0, 32'h0040_00F8, 1'b0, 5, 0, 0);
        bus.redirect_valid = 1'b0;
        step(); chk_state("penult", 1'b1, 32'h0040_00FC, 1'b0, 5, 32'h0040_00F8, 32'hA000_003E);
        step(); chk_state("last", 1'b1, 32'h0040_0100, 1'b0, 6, 32'h0040_00FC, 32'hA000_003F);

        // Fetch past end of segment faults, no wrap
        step(); chk_state("end_fault", 1'b0, 32'h0040_0100, 1'b1, 7, 0, 0);
        step(); chk_state("halt_hold", 1'b0, 32'h0040_0100, 1'b1, 7, 0, 0);
        chk("halt_inst", bus.inst, 32'hA000_003F);
        chk("halt_ipc",  bus.inst_pc, 32'h0040_00FC);

        // Redirect out of HALT clears the fault and resumes
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0000;
        step(); chk_state("clear", 1'b0, 32'h0040_0000, 1'b0, 7, 0, 0);
        bus.redirect_valid = 1'b0;
        step(); chk_state("resume", 1'b1, 32'h0040_0004, 1'b0, 7, 32'h0040_0000, 32'hA000_0000);

        // Misaligned redirect target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0002;
        step(); chk_state("rd_mis", 1'b0, 32'h0040_0002, 1'b0, 8, 0, 0);
        bus.redirect_valid = 1'b0;
        step(); chk_state("mis_fault", 1'b0, 32'h0040_0002, 1'b1, 8, 0, 0);
        step(); chk_state("mis_halt", 1'b0, 32'h0040_0002, 1'b1, 8, 0, 0);

        // Below-segment redirect target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h003F_FFFC;
        step(); chk_state("rd_low", 1'b0, 32'h003F_FFFC, 1'b0, 8, 0, 0);
        bus.redirect_valid = 1'b0;
        step(); chk_state("low_fault", 1'b0, 32'h003F_FFFC, 1'b1, 8, 0, 0);

        // Restart stream, then reset mid-stream at pc 0x400010
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0000;
        step(); chk_state("clear2", 1'b0, 32'h0040_0000, 1'b0, 8, 0, 0);
        bus.redirect_valid = 1'b0;
        step(); chk_state("s2_0", 1'b1, 32'h0040_0004, 1'b0, 8,  32'h0040_0000, 32'hA000_0000);
        step(); chk_state("s2_1", 1'b1, 32'h0040_0008, 1'b0, 9,  32'h0040_0004, 32'hA000_0001);
        step(); chk_state("s2_2", 1'b1, 32'h0040_000C, 1'b0, 10, 32'h0040_0008, 32'hA000_0002);
        step(); chk_state("s2_3", 1'b1, 32'h0040_0010, 1'b0, 11, 32'h0040_000C, 32'hA000_0003);

        rst_n = 1'b0;
        step(); chk_state("mid_rst", 1'b0, 32'h0040_0000, 1'b0, 0, 0, 0);
        chk("mid_rst_inst", bus.inst, 32'h0);
        chk("mid_rst_ipc",  bus.inst_pc, 32'h0);
        rst_n = 1'b1;
        step(); chk_state("restart0", 1'b1, 32'h0040_0004, 1'b0, 0, 32'h0040_0000, 32'hA000_0000);
        step(); chk_state("restart1", 1'b1, 32'h0040_0008, 1'b0, 1, 32'h0040_0004, 32'hA000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch initiator for the memory system: owns the program counter, drives the address into the combinational instruction ROM and registers the returned word into a valid/ready output stage for the decode side. It fetches sequentially from the text segment base, honours downstream back-pressure, takes branch/jump redirects, and halts with a sticky fault on any out-of-segment or misaligned fetch.

## Interface
- DATA_WIDTH, 32, width of address, instruction and PC
- TEXT_BASE, 32'h0040_0000, byte address of the first ROM word
- TEXT_WORDS, 64, ROM depth in words; legal range is TEXT_BASE to TEXT_BASE+4*TEXT_WORDS-4
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- rom_addr  out  DATA_WIDTH  byte address to ROM, always equal to internal pc
- rom_q  in  DATA_WIDTH  ROM data, combinational from rom_addr in the same cycle
- redirect_valid  in  1  load redirect_pc this cycle (branch/jump taken)
- redirect_pc  in  DATA_WIDTH  new fetch byte address
- inst_valid  out  1  inst/inst_pc hold a fetched word
- inst_ready  in  1  consumer accepts the word this cycle
- inst  out  DATA_WIDTH  fetched instruction
- inst_pc  out  DATA_WIDTH  byte address inst was fetched from
- fetch_fault  out  1  sticky: fetch halted on illegal pc
- fetch_count  out  DATA_WIDTH  number of completed inst handshakes since reset

## Operation
- States: FETCH, HALT.
- Load-eligible cycle: state FETCH and (inst_valid==0 or inst_ready==1).
- Legal pc: pc[1:0]==0 and TEXT_BASE <= pc <= TEXT_BASE+4*(TEXT_WORDS-1); unsigned compare, 32-bit.
- Priority per cycle: reset > redirect > fault > load.
- Redirect (either state): pc <= redirect_pc, inst_valid <= 0 (output word flushed even if inst_ready high that cycle), fetch_fault <= 0, state <= FETCH. Handshake on the flushed word still counts if inst_valid and inst_ready were both high.
- FETCH, load-eligible, pc legal: inst <= rom_q, inst_pc <= pc, inst_valid <= 1, pc <= pc+4 (mod 2^32).
- FETCH, load-eligible, pc illegal: state <= HALT, fetch_fault <= 1, inst_valid <= 0, pc unchanged.
- FETCH, not load-eligible (valid && !ready): all outputs and pc hold.
- HALT: pc, inst, inst_pc hold; inst_valid 0; leaves only by redirect or reset. Redirect to an illegal pc is accepted; fault reasserts on its fetch.
- No wrap at end of segment: sequential fetch past the last word faults.
- fetch_count increments on every cycle with inst_valid && inst_ready; wraps mod 2^32.

## Timing
- Reset values: pc=TEXT_BASE, rom_addr=TEXT_BASE, inst=0, inst_pc=0, inst_valid=0, fetch_fault=0, fetch_count=0, state FETCH.
- First word: inst_valid high after the first rising edge with rst_n high; inst_pc=TEXT_BASE.
- Throughput: one word per cycle while inst_ready held high.
- Redirect latency: redirect at edge N, inst_valid low after N, word from redirect_pc valid after N+1.
- Fault: flagged one edge after the load-eligible cycle that saw the illegal pc.
- rst_n low mid-stream: all state returns to reset values on that edge, no partial handshake counted.

## Structure
- Shared package mem_sys_pkg: TEXT_BASE, word size in bytes (4), state enum {FETCH, HALT}.
- Sub-module fetch_addr_check (combinational legal-pc test, parameterised by TEXT_BASE/TEXT_WORDS); rest in one module.

## Test plan
- Reset release, inst_ready=1, ROM with word k = 32'hA000_0000+k -> inst_pc 0x400000,0x400004,... on consecutive cycles, inst matches, fetch_count=n after n cycles.
- Hold inst_ready=0 for 3 cycles after first word -> inst/inst_pc stable at 0x400000, pc stays 0x400004, fetch_count unchanged; release -> 0x400004 next.
- Redirect to 0x400020 while valid&&!ready -> old word dropped, next valid word inst_pc=0x400020.
- Run to last word 0x4000FC, then next fetch -> fetch_fault=1, inst_valid=0, state HALT; redirect to 0x400000 clears fault and resumes.
- Redirect to 0x400002 and to 0x3FFFFC -> fetch_fault=1 one edge later, no valid word issued.
- rst_n low for one cycle mid-stream at pc 0x400010 -> all outputs reset, restart from 0x400000, fetch_count=0.
